alsu_arbiter: RTL
=================

Name: alsu_arbiter

Overview:
- Shares one ALSU instance between two requesters (R0, R1); one command in flight at a time.
- Each command is a packed ALSU control word. The block arbitrates round-robin, with optional per-requester lock, drives the ALSU input ports, and waits the ALSU pipeline latency.
- Captures alsu_out and returns it tagged with the requester ID. Sits between the two command sources and the ALSU.

Parameters:
ALSU_LATENCY, 2, edges from ALSU input change to valid alsu_out (ALSU input reg plus output reg)
RST_PRIORITY, 0, requester favoured by the round-robin pointer after reset (0 or 1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
r0_valid  in  1  R0 command valid
r0_ready  out  1  R0 command accepted this cycle
r0_cmd  in  16  R0 command: [15:13]opcode [12:10]a [9:7]b [6]cin [5]serialin [4]direction [3]red_op_a [2]red_op_b [1]bypass_a [0]bypass_b
r0_lock  in  1  R0 requests exclusive ownership of the ALSU
r1_valid/r1_ready/r1_cmd/r1_lock  same widths and meaning for R1
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  1  requester that issued the command
rsp_data  out  6  captured alsu_out
rsp_err  out  1  1 = illegal opcode (6 or 7), rejected without issue
alsu_a, alsu_b, alsu_opcode  out  3 each  to ALSU
alsu_cin, alsu_serialin, alsu_direction, alsu_red_op_a, alsu_red_op_b, alsu_bypass_a, alsu_bypass_b  out  1 each  to ALSU
alsu_out  in  6  from ALSU

Behaviour:
- Reset (async, rst=1):
  - State is IDLE. rr_ptr = RST_PRIORITY. lock_owner is cleared.
  - All outputs are 0: ready, rsp_*, and every alsu_* (drives the AND of 0,0).
  - Reset mid-operation aborts the in-flight command; no response is produced.
- FSM: IDLE -> WAIT -> RESP -> IDLE. IDLE -> RESP directly on an illegal opcode.
- IDLE eligibility:
  - If lock_owner is set and that owner's lock = 1, only the owner is eligible.
  - Otherwise lock_owner is cleared and both requesters are eligible.
- IDLE grant:
  - If both requesters are eligible and valid, grant rr_ptr.
  - If only one is valid, grant it.
  - rx_ready is asserted combinationally for the granted requester only, in IDLE only. Accept occurs at the edge where valid&ready.
- On accept at edge T:
  - rr_ptr <= other requester.
  - If rx_lock = 1, lock_owner <= x.
  - rsp_id <= x.
- Legal opcode (0-5) on accept:
  - All alsu_* registers load from the cmd fields at edge T.
  - State -> WAIT, cnt <= ALSU_LATENCY.
- Illegal opcode (6 or 7) on accept:
  - alsu_* are left unchanged.
  - State -> RESP with rsp_err=1 and rsp_data=0.
  - rsp_valid is high after edge T: 1-cycle latency.
- WAIT:
  - cnt decrements each edge.
  - At the edge where cnt = 0: rsp_data <= alsu_out, rsp_err <= 0, state -> RESP.
  - Accept -> rsp_valid high after ALSU_LATENCY+1 edges (3 at default).
- RESP:
  - rsp_valid = 1, with rsp_id/rsp_data/rsp_err held stable until rsp_valid & rsp_ready.
  - Then rsp_valid <= 0 and state -> IDLE.
  - No new command is accepted while in WAIT or RESP.
- alsu_* hold the last issued command until the next legal accept.
  - Shift/rotate (opcode 4/5) keep advancing on the held inputs.
  - rsp_data is the value exactly ALSU_LATENCY edges after issue.
- Lock release: lock_owner clears in IDLE when the owner's lock = 0. The other requester is eligible in that same cycle.
- Simultaneous events:
  - Both valid with no lock: rr_ptr wins.
  - Both lock while both valid: the granted one becomes owner.

Decomposition:
- Shared package alsu_pkg holds:
  - opcode constants OP_AND=0, OP_XOR=1, OP_ADD=2, OP_MUL=3, OP_SHIFT=4, OP_ROT=5
  - CMD_W=16 and the cmd field bit positions
  - the FSM state encodings
- One sub-module, alsu_rr_arb: 2-way round-robin with lock mask.
  - Inputs: valid[1:0], lock[1:0], enable.
  - Outputs: grant one-hot, grant_id.

Test Plan:
1. Reset, then R0 issues ADD a=3 b=2 cin=0 -> r0_ready pulses 1 cycle; rsp_valid 3 edges later with rsp_id=0, rsp_data=5, rsp_err=0.
2. R0 and R1 continuously valid (R0 AND a=5 b=3; R1 XOR a=5 b=3), no lock -> grants alternate 0,1,0,1 with rsp_data 1 and 6 alternately.
3. R0 lock=1 for 3 commands while R1 valid -> three consecutive rsp_id=0. R0 drops lock -> R1 is granted on the next IDLE cycle.
4. R1 issues opcode 7 -> rsp_valid after 1 edge, rsp_err=1, rsp_data=0; alsu_opcode is unchanged from its previous value.
5. rsp_ready held 0 for 5 cycles after MUL a=3 b=3 -> rsp_data=9 stays stable; no r0_ready/r1_ready during the stall.
6. rst asserted during WAIT -> all outputs 0 asynchronously; no rsp_valid after release; the next grant goes to RST_PRIORITY.

Source files
------------

// File: rtl/alsu_pkg.sv
// Purpose: shared definitions for the ALSU arbiter slice (command layout, opcodes, FSM states).
// Latency: n/a (constants, types and one helper function only).
// Backpressure: n/a.
package alsu_pkg;

  localparam int CMD_W = 16;

  // Command word bit positions
  localparam int OPC_HI    = 15;
  localparam int OPC_LO    = 13;
  localparam int A_HI      = 12;
  localparam int A_LO      = 10;
  localparam int B_HI      = 9;
  localparam int B_LO      = 7;
  localparam int CIN_BIT   = 6;
  localparam int SERIN_BIT = 5;
  localparam int DIR_BIT   = 4;
  localparam int REDA_BIT  = 3;
  localparam int REDB_BIT  = 2;
  localparam int BYPA_BIT  = 1;
  localparam int BYPB_BIT  = 0;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_XOR   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_MUL   = 3'd3;
  localparam logic [2:0] OP_SHIFT = 3'd4;
  localparam logic [2:0] OP_ROT   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Opcodes 6 and 7 have no ALSU function and are bounced with an error.
  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_ROT);
  endfunction

endpackage

// File: rtl/alsu_rr_arb.sv
// Purpose: 2-way round-robin arbiter with a sticky lock owner.
// Latency: grant is combinational from valid/lock; pointer and owner update on the accept edge.
// Backpressure: grants only while enable is high; a granted request is always accepted.
// Ports: clk/rst, valid[1:0], lock[1:0], enable -> grant[1:0] (one-hot), grant_id.
module alsu_rr_arb #(
  parameter int RST_PRIORITY = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic [1:0] lock,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic       rr_ptr;
  logic       owner_vld;
  logic       owner_id;
  logic       owner_hold;
  logic [1:0] elig;
  logic [1:0] req;

  always_comb begin
    // The owner keeps exclusivity only while it still holds its lock.
    owner_hold = owner_vld & lock[owner_id];
    elig       = owner_hold ? (owner_id ? 2'b10 : 2'b01) : 2'b11;
    req        = valid & elig & {2{enable}};
    grant      = 2'b00;
    if (req == 2'b11) begin
      grant = rr_ptr ? 2'b10 : 2'b01;
    end else begin
      grant = req;
    end
    grant_id = grant[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= (RST_PRIORITY != 0);
      owner_vld <= 1'b0;
      owner_id  <= 1'b0;
    end else if (enable) begin
      if (|grant) begin
        rr_ptr <= ~grant_id;
      end
      if (|grant && lock[grant_id]) begin
        owner_vld <= 1'b1;
        owner_id  <= grant_id;
      end else if (!owner_hold) begin
        owner_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alsu_arbiter.sv
// Purpose: shares one ALSU between two command sources, one command in flight, tagged responses.
// Latency: accept -> rsp_valid after ALSU_LATENCY+1 edges (legal) or 1 edge (illegal opcode).
// Backpressure: no command accepted outside IDLE; response held until rsp_valid & rsp_ready.
// Ports: r0_*/r1_* command sources (valid/ready/cmd/lock), rsp_* response, alsu_* ALSU drive, alsu_out result.
module alsu_arbiter
  import alsu_pkg::*;
#(
  parameter int ALSU_LATENCY = 2,
  parameter int RST_PRIORITY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [CMD_W-1:0] r0_cmd,
  input  logic             r0_lock,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [CMD_W-1:0] r1_cmd,
  input  logic             r1_lock,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [5:0]       rsp_data,
  output logic             rsp_err,
  output logic [2:0]       alsu_a,
  output logic [2:0]       alsu_b,
  output logic [2:0]       alsu_opcode,
  output logic             alsu_cin,
  output logic             alsu_serialin,
  output logic             alsu_direction,
  output logic             alsu_red_op_a,
  output logic             alsu_red_op_b,
  output logic             alsu_bypass_a,
  output logic             alsu_bypass_b,
  input  logic [5:0]       alsu_out
);

  localparam int CW = (ALSU_LATENCY < 2) ? 1 : $clog2(ALSU_LATENCY + 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [1:0]       grant;
  logic             grant_id;
  logic             enable;
  logic             accept;
  logic [CMD_W-1:0] sel_cmd;

  // Gating with rst keeps the ready outputs low while reset is asserted.
  assign enable   = (state == ST_IDLE) & ~rst;
  assign r0_ready = grant[0];
  assign r1_ready = grant[1];
  assign accept   = |grant;
  assign sel_cmd  = grant_id ? r1_cmd : r0_cmd;

  alsu_rr_arb #(
    .RST_PRIORITY (RST_PRIORITY)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .valid    ({r1_valid, r0_valid}),
    .lock     ({r1_lock, r0_lock}),
    .enable   (enable),
    .grant    (grant),
    .grant_id (grant_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      rsp_valid      <= 1'b0;
      rsp_id         <= 1'b0;
      rsp_data       <= '0;
      rsp_err        <= 1'b0;
      alsu_a         <= '0;
      alsu_b         <= '0;
      alsu_opcode    <= '0;
      alsu_cin       <= 1'b0;
      alsu_serialin  <= 1'b0;
      alsu_direction <= 1'b0;
      alsu_red_op_a  <= 1'b0;
      alsu_red_op_b  <= 1'b0;
      alsu_bypass_a  <= 1'b0;
      alsu_bypass_b  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rsp_id <= grant_id;
            if (op_legal(sel_cmd[OPC_HI:OPC_LO])) begin
              alsu_opcode    <= sel_cmd[OPC_HI:OPC_LO];
              alsu_a         <= sel_cmd[A_HI:A_LO];
              alsu_b         <= sel_cmd[B_HI:B_LO];
              alsu_cin       <= sel_cmd[CIN_BIT];
              alsu_serialin  <= sel_cmd[SERIN_BIT];
              alsu_direction <= sel_cmd[DIR_BIT];
              alsu_red_op_a  <= sel_cmd[REDA_BIT];
              alsu_red_op_b  <= sel_cmd[REDB_BIT];
              alsu_bypass_a  <= sel_cmd[BYPA_BIT];
              alsu_bypass_b  <= sel_cmd[BYPB_BIT];
              cnt            <= CW'(ALSU_LATENCY);
              state          <= ST_WAIT;
            end else begin
              // ALSU inputs stay untouched so a running shift/rotate is not disturbed.
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          // cnt reaches 0 one edge after the ALSU output reflects the issued inputs.
          if (cnt == '0) begin
            rsp_data  <= alsu_out;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
